// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size and FSM state
// encodings, the memory word geometry, and the byte-mask / alignment helpers.
package lsu_pkg;

    localparam int WORD_BYTES_2POW = 3;

    typedef enum logic [1:0] {
        LSU_BYTE   = 2'd0,
        LSU_HALF   = 2'd1,
        LSU_WORD   = 2'd2,
        LSU_DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        MERGE   = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    // Byte-enable mask of an access of the given size starting at byte lane.
    function automatic logic [7:0] size_to_mask(input lsu_size_e size,
                                                input logic [WORD_BYTES_2POW-1:0] lane);
        logic [7:0] base;
        case (size)
            LSU_BYTE: base = 8'h01;
            LSU_HALF: base = 8'h03;
            LSU_WORD: base = 8'h0F;
            default:  base = 8'hFF;
        endcase
        return base << lane;
    endfunction

    // Natural alignment check: the access must not straddle its own size.
    function automatic logic is_misaligned(input lsu_size_e size,
                                           input logic [WORD_BYTES_2POW-1:0] lane);
        case (size)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return lane[0];
            LSU_WORD: return |lane[1:0];
            default:  return |lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane datapath: extracts and extends a load result from a
// memory word, and merges store bytes into a memory word. Used for loads in
// RD_WAIT and for the store write data in MERGE.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]      word,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  lsu_size_e                  size,
    input  logic [WORD_BYTES_2POW-1:0] lane,
    input  logic                       is_unsigned,
    output logic [DATA_WIDTH-1:0]      load_data,
    output logic [DATA_WIDTH-1:0]      merged
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] placed;
    logic [7:0]            mask;
    logic                  sign;

    // Load path: right-justify the addressed bytes, then sign or zero extend.
    always_comb begin
        shifted   = word >> {lane, 3'b000};
        sign      = ~is_unsigned;
        load_data = shifted;
        case (size)
            LSU_BYTE: load_data = {{56{sign & shifted[7]}},  shifted[7:0]};
            LSU_HALF: load_data = {{48{sign & shifted[15]}}, shifted[15:0]};
            LSU_WORD: load_data = {{32{sign & shifted[31]}}, shifted[31:0]};
            default:  load_data = shifted;
        endcase
    end

    // Store path: move the low store bytes to the lane and replace only masked bytes.
    always_comb begin
        mask   = size_to_mask(size, lane);
        placed = wdata << {lane, 3'b000};
        merged = word;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) merged[8*i +: 8] = placed[8*i +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit between execute and a synchronous-read DataMemory.
// Sub-doubleword stores are done as read-modify-write of the aligned word.
// Optional access counters are enabled with the LSU_ACCESS_COUNT_EN macro.
//
// state   | meaning
// IDLE    | ready for a request
// RD_WAIT | read strobe cycle, then read-data cycle (result/word captured)
// MERGE   | write strobe with merged (or full double) store data
// RESP    | one-cycle response pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_write_in,
    input  logic [1:0]            req_size_in,
    input  logic                  req_unsigned_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [DATA_WIDTH-1:0] req_wdata_in,
    output logic                  resp_valid_out,
    output logic [DATA_WIDTH-1:0] resp_rdata_out,
    output logic                  resp_misaligned_out,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_writeEnable_out,
    output logic                  mem_readEnable_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in
`ifdef LSU_ACCESS_COUNT_EN
    ,
    output logic [31:0]           load_count_out,
    output logic [31:0]           store_count_out,
    output logic [31:0]           fault_count_out
`endif
);

    lsu_state_e            state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    lsu_size_e             size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic                  mis_q;
    logic                  rd_first;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    lsu_size_e                  req_size;
    logic [WORD_BYTES_2POW-1:0] req_lane;
    logic                       req_mis;
    logic                       accept;
    logic [DATA_WIDTH-1:0]      align_word;
    logic [DATA_WIDTH-1:0]      load_data;
    logic [DATA_WIDTH-1:0]      merged;

    assign req_size = lsu_size_e'(req_size_in);
    assign req_lane = req_addr_in[WORD_BYTES_2POW-1:0];
    assign req_mis  = is_misaligned(req_size, req_lane);
    assign accept   = (state == IDLE) && req_valid_in;

    // MERGE works from the captured word; RD_WAIT extracts straight from memory.
    assign align_word = (state == MERGE) ? word_q : mem_data_in;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word        (align_word),
        .wdata       (wdata_q),
        .size        (size_q),
        .lane        (addr_q[WORD_BYTES_2POW-1:0]),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // State register and request/datapath registers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= LSU_BYTE;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            mis_q      <= 1'b0;
            rd_first   <= 1'b0;
            word_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr_in;
                size_q     <= req_size;
                wdata_q    <= req_wdata_in;
                write_q    <= req_write_in;
                unsigned_q <= req_unsigned_in;
                mis_q      <= req_mis;
                // A full double store skips the read; word_q = 0 with an all-ones mask yields wdata.
                rd_first   <= ~req_mis & ~(req_write_in & (req_size == LSU_DOUBLE));
                word_q     <= '0;
                rdata_q    <= '0;
            end else if (state == RD_WAIT) begin
                rd_first <= 1'b0;
                if (!rd_first) begin
                    word_q <= mem_data_in;
                    if (!write_q) rdata_q <= load_data;
                end
            end
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_next          = state;
        req_ready_out       = 1'b0;
        resp_valid_out      = 1'b0;
        resp_rdata_out      = '0;
        resp_misaligned_out = 1'b0;
        mem_address_out     = '0;
        mem_data_out        = '0;
        mem_writeEnable_out = 1'b0;
        mem_readEnable_out  = 1'b0;
        if (state != IDLE) begin
            mem_address_out = {addr_q[ADDR_WIDTH-1:WORD_BYTES_2POW], {WORD_BYTES_2POW{1'b0}}};
        end
        case (state)
            IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    if (req_mis)                                        state_next = RESP;
                    else if (req_write_in && (req_size == LSU_DOUBLE))  state_next = MERGE;
                    else                                                state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_readEnable_out = rd_first;
                if (!rd_first) state_next = write_q ? MERGE : RESP;
            end
            MERGE: begin
                mem_writeEnable_out = 1'b1;
                mem_data_out        = merged;
                state_next          = RESP;
            end
            RESP: begin
                resp_valid_out      = 1'b1;
                resp_rdata_out      = rdata_q;
                resp_misaligned_out = mis_q;
                state_next          = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LSU_ACCESS_COUNT_EN
    // Completed-access counters; a misaligned access counts only as a fault.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            load_count_out  <= '0;
            store_count_out <= '0;
            fault_count_out <= '0;
        end else if (state == RESP) begin
            if (mis_q)        fault_count_out <= fault_count_out + 32'd1;
            else if (write_q) store_count_out <= store_count_out + 32'd1;
            else              load_count_out  <= load_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory model.
// Define LSU_ACCESS_COUNT_EN to also check the access counters.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_write_in = 1'b0;
    logic [1:0]  req_size_in = 2'd0;
    logic        req_unsigned_in = 1'b0;
    logic [63:0] req_addr_in = '0;
    logic [63:0] req_wdata_in = '0;
    logic        resp_valid_out;
    logic [63:0] resp_rdata_out;
    logic        resp_misaligned_out;
    logic [63:0] mem_address_out;
    logic [63:0] mem_data_out;
    logic        mem_writeEnable_out;
    logic        mem_readEnable_out;
    logic [63:0] mem_data_in = '0;
`ifdef LSU_ACCESS_COUNT_EN
    logic [31:0] load_count_out, store_count_out, fault_count_out;
`endif

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk_in              (clk),
        .reset_n_in          (rst_n),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_write_in        (req_write_in),
        .req_size_in         (req_size_in),
        .req_unsigned_in     (req_unsigned_in),
        .req_addr_in         (req_addr_in),
        .req_wdata_in        (req_wdata_in),
        .resp_valid_out      (resp_valid_out),
        .resp_rdata_out      (resp_rdata_out),
        .resp_misaligned_out (resp_misaligned_out),
        .mem_address_out     (mem_address_out),
        .mem_data_out        (mem_data_out),
        .mem_writeEnable_out (mem_writeEnable_out),
        .mem_readEnable_out  (mem_readEnable_out),
        .mem_data_in         (mem_data_in)
`ifdef LSU_ACCESS_COUNT_EN
        ,
        .load_count_out      (load_count_out),
        .store_count_out     (store_count_out),
        .fault_count_out     (fault_count_out)
`endif
    );

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          reads;
        int          writes;
        int          lat;
        int          acc;
        logic [63:0] waddr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_n = 0;
    int          resp_n = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          n_load = 0, n_store = 0, n_fault = 0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  ref_mem[128];
    logic [63:0] tmem[16];

    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory stand-in: synchronous read, write on strobe.
    always @(posedge clk) begin
        if (mem_readEnable_out) mem_data_in <= tmem[mem_address_out[6:3]];
        if (mem_writeEnable_out) tmem[mem_address_out[6:3]] <= mem_data_out;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: handshake/strobe sanity every cycle, scoreboard pop on response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            resp_n = acc_n;
            rd_cnt = 0;
            wr_cnt = 0;
            n_load = 0; n_store = 0; n_fault = 0;
        end else begin
            chk("ready", {63'd0, req_ready_out}, {63'd0, acc_n == resp_n});
            if (mem_readEnable_out && mem_writeEnable_out) chk("strobe_overlap", 64'd1, 64'd0);
            if (mem_readEnable_out) rd_cnt++;
            if (mem_writeEnable_out) begin
                wr_cnt++;
                last_wdata = mem_data_out;
            end
            if ((mem_readEnable_out || mem_writeEnable_out) && q.size() > 0)
                chk("mem_addr", mem_address_out, q[0].waddr);
            if (resp_valid_out) begin
                if (q.size() == 0) begin
                    chk("spurious_resp", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", resp_rdata_out, e.rdata);
                    chk("misaligned", {63'd0, resp_misaligned_out}, {63'd0, e.mis});
                    chk("read_strobes", 64'(rd_cnt), 64'(e.reads));
                    chk("write_strobes", 64'(wr_cnt), 64'(e.writes));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    if (e.mis) n_fault++;
                    else if (e.writes != 0) n_store++;
                    else n_load++;
                end
                resp_n++;
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Drive one request, wait for acceptance, then apply it to the reference model.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, input bit keep);
        exp_t e;
        int nb, n;
        logic [63:0] v;
        @(negedge clk);
        req_valid_in = 1'b1; req_write_in = w; req_size_in = sz;
        req_unsigned_in = u; req_addr_in = a; req_wdata_in = wd;
        n = 0;
        while (!req_ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 64'd1, 64'd0);
            req_valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        nb = 1 << sz;
        e.mis = (a % nb) != 0;
        e.rdata = '0;
        e.waddr = a & ~64'h7;
        e.reads = 0;
        e.writes = 0;
        e.acc = cyc;
        if (e.mis) begin
            e.lat = 0;
        end else if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
            e.writes = 1;
            e.reads = (nb == 8) ? 0 : 1;
            e.lat = (nb == 8) ? 1 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
            if (!u && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
            e.rdata = v;
            e.reads = 1;
            e.lat = 2;
        end
        q.push_back(e);
        acc_n++;
        if (!keep) req_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (acc_n != resp_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] v = '0;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_mem[idx*8 + b];
        return v;
    endfunction

    task automatic check_reset_outputs(input string name);
        chk({name, "_ready"}, {63'd0, req_ready_out}, 64'd1);
        chk({name, "_resp"}, {62'd0, resp_valid_out, resp_misaligned_out}, 64'd0);
        chk({name, "_rdata"}, resp_rdata_out, 64'd0);
        chk({name, "_addr"}, mem_address_out, 64'd0);
        chk({name, "_wdata"}, mem_data_out, 64'd0);
        chk({name, "_strobes"}, {62'd0, mem_readEnable_out, mem_writeEnable_out}, 64'd0);
`ifdef LSU_ACCESS_COUNT_EN
        chk({name, "_counts"}, {32'd0, load_count_out | store_count_out | fault_count_out}, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] init_w;
        logic [63:0] a, wd;
        logic [1:0]  sz;
        int          gap;
        for (int i = 0; i < 16; i++) begin
            init_w = {$urandom, $urandom};
            if (i == 8) init_w = 64'h8877665544332211;
            tmem[i] = init_w;
            for (int b = 0; b < 8; b++) ref_mem[i*8 + b] = init_w[8*b +: 8];
        end

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on the word at 0x40.
        issue(1'b0, 2'd0, 1'b0, 64'h47, 64'd0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 64'h47, 64'd0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 64'h42, 64'hBEEF, 1'b0);
        drain();
        chk("half_store_merge", last_wdata, 64'h88776655BEEF2211);
        issue(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 1'b0);
        issue(1'b1, 2'd3, 1'b0, 64'h48, 64'h0123456789ABCDEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 64'h42, 64'd0, 1'b0);
        drain();
`ifdef LSU_ACCESS_COUNT_EN
        chk("fault_count_directed", {32'd0, fault_count_out}, 64'd1);
`endif
        // Back-to-back with valid held across both requests.
        issue(1'b0, 2'd3, 1'b0, 64'h48, 64'd0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 64'h44, 64'd0, 1'b0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom};
            gap = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                  (gap == 0) && (i != 299));
            repeat (gap) @(negedge clk);
        end
        drain();

        // Reset during RD_WAIT of a byte store: no write, no response.
        @(negedge clk);
        req_valid_in = 1'b1; req_write_in = 1'b1; req_size_in = 2'd0;
        req_unsigned_in = 1'b0; req_addr_in = 64'h13; req_wdata_in = 64'h5A ^ {$urandom, $urandom};
        @(posedge clk);
        #1;
        acc_n++;
        req_valid_in = 1'b0;
        @(negedge clk);
        chk("abort_rd_strobe", {63'd0, mem_readEnable_out}, 64'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_quiet", {62'd0, mem_writeEnable_out, resp_valid_out}, 64'd0);
        end
        rst_n = 1'b1;
        chk("abort_mem_kept", tmem[2], ref_word(2));
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 1'b0);
        drain();

        for (int i = 0; i < 16; i++) chk("final_mem", tmem[i], ref_word(i));
`ifdef LSU_ACCESS_COUNT_EN
        @(negedge clk);
        chk("load_count", {32'd0, load_count_out}, 64'(n_load));
        chk("store_count", {32'd0, store_count_out}, 64'(n_store));
        chk("fault_count", {32'd0, fault_count_out}, 64'(n_fault));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
